lane_packet_sender: RTL and testbench
=====================================

LANE_PACKET_SENDER -- requirements
Module: lane_packet_sender

Interface
REQ-001 Parameter NUM_LANES, default 4: number of parallel serial data lanes.
REQ-002 Parameter PAYLOAD_BITS, default 32: packet payload width; SHALL be a multiple of NUM_LANES; W = PAYLOAD_BITS/NUM_LANES.
REQ-003 Parameter TYPE_BITS, default 3: packet type field width; SHALL satisfy TYPE_BITS+1 <= W.
REQ-004 Parameter TIMEOUT_CYCLES, default 16: ack wait window, in cycles.
REQ-005 Parameter MAX_RETRIES, default 2: retransmissions allowed after the first send.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst_l  in  1  asynchronous, active-low reset.
REQ-008 send_valid  in  1  request to send a packet.
REQ-009 send_ready  out  1  high only in IDLE; a handshake occurs when send_valid and send_ready are both high at a rising edge.
REQ-010 send_type  in  TYPE_BITS  packet type, captured at handshake.
REQ-011 send_need_ack  in  1  1 means wait for an ack and retransmit on timeout; 0 means fire-and-forget; captured at handshake.
REQ-012 send_payload  in  PAYLOAD_BITS  payload, captured at handshake.
REQ-013 ack_valid  in  1  one-cycle ack strobe from the receive path.
REQ-014 ack_seq  in  1  sequence bit carried by the ack.
REQ-015 serial_out_h  out  1  header lane, registered.
REQ-016 serial_out  out  NUM_LANES  data lanes, registered.
REQ-017 send_done  out  1  one-cycle pulse when a packet completes successfully.
REQ-018 send_fail  out  1  one-cycle pulse when retries are exhausted.
REQ-019 cur_seq  out  1  sequence bit used for the current or next packet.

Function
REQ-020 States SHALL be IDLE, SEND and WAIT_ACK.
REQ-021 On handshake, payload, type and need_ack SHALL be latched; later input changes SHALL NOT affect the frame. The state moves to SEND.
REQ-022 A frame SHALL occupy W+1 consecutive cycles, starting in the cycle after the handshake or retransmit decision.
REQ-023 Data lane framing: in frame cycle 0 every data lane SHALL drive start bit 1.
REQ-024 Data lane framing: in cycles 1..W, lane i SHALL drive send_payload[(i+1)*W-1 : i*W], MSB first.
REQ-025 serial_out_h framing: cycle 0 is 1; cycles 1..TYPE_BITS carry the type, MSB first; cycle TYPE_BITS+1 carries cur_seq; remaining cycles are 0.
REQ-026 Outside SEND, all serial outputs SHALL be 0.
REQ-027 After the last frame cycle with need_ack=0, the next cycle SHALL be IDLE with send_done=1 and cur_seq toggled.
REQ-028 After the last frame cycle with need_ack=1, the next cycle SHALL enter WAIT_ACK with the timer at 0; the timer increments each WAIT_ACK cycle.
REQ-029 In WAIT_ACK, ack_valid with ack_seq==cur_seq SHALL produce IDLE next cycle, send_done=1 for that cycle, cur_seq toggled and the retry count cleared.
REQ-030 ack_valid with ack_seq!=cur_seq SHALL be ignored.
REQ-031 ack_valid in IDLE or SEND SHALL be ignored.
REQ-032 When timer==TIMEOUT_CYCLES-1 with no matching ack: if retries<MAX_RETRIES, retries SHALL increment and the FSM SHALL re-enter SEND with an identical frame, including the same seq.
REQ-033 When timer==TIMEOUT_CYCLES-1 with no matching ack and retries==MAX_RETRIES: the FSM SHALL go to IDLE with send_fail=1 for one cycle; cur_seq is NOT toggled.
REQ-034 A matching ack in the same cycle as the timeout SHALL take priority, giving success.
REQ-035 send_valid outside IDLE SHALL be ignored, with no queuing.
REQ-036 send_ready SHALL be high in the same cycle that send_done or send_fail pulses.
REQ-037 send_done and send_fail SHALL never assert together.

Reset
REQ-038 When rst_l is low: state IDLE, send_ready=1, serial_out_h=0, serial_out=0, send_done=0, send_fail=0, cur_seq=0, timer=0, retries=0.
REQ-039 Reset mid-frame or in WAIT_ACK SHALL abort the packet immediately, with no done or fail pulse.
REQ-040 Release of rst_l SHALL take effect at the next clock edge.

Verification (defaults unless stated)
REQ-041 Send payload 32'hA5C30F81, type 3'b101, need_ack=0, handshake at edge T; the required response below covers data lanes, header lane and completion.
- Data lanes, cycles T+1..T+9: lane0 = 1,1000_0001; lane3 = 1,1010_0101.
- Header lane: 1,1,0,1,0,0,0,0,0.
- Completion: send_done at T+10; cur_seq becomes 1.
REQ-042 need_ack=1, ack(seq=0) given 3 cycles into WAIT_ACK -> send_done next cycle, cur_seq=1. A prior ack(seq=1) in WAIT_ACK -> no effect.
REQ-043 need_ack=1, no ack -> three frames total, each separated by 16 WAIT_ACK cycles, all with seq bit 0. Then send_fail=1 for one cycle and cur_seq stays 0.
REQ-044 Matching ack on the timeout cycle of the first wait -> send_done, no retransmit.
REQ-045 rst_l low during frame cycle 4 -> all outputs 0 and send_ready=1 immediately; no pulses.
REQ-046 NUM_LANES=8, PAYLOAD_BITS=64 -> 9-cycle frame; lane7 carries payload[63:56].

Source files
------------

// File: rtl/lane_packet_sender.sv
// lane_packet_sender: frames a latched payload across NUM_LANES serial data
// lanes plus a header lane, optionally waits for a sequence-matched ack and
// retransmits the identical frame on timeout until the retry budget runs out.
module lane_packet_sender #(
  parameter int NUM_LANES      = 4,
  parameter int PAYLOAD_BITS   = 32,
  parameter int TYPE_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    send_valid,
  output logic                    send_ready,
  input  logic [TYPE_BITS-1:0]    send_type,
  input  logic                    send_need_ack,
  input  logic [PAYLOAD_BITS-1:0] send_payload,
  input  logic                    ack_valid,
  input  logic                    ack_seq,
  output logic                    serial_out_h,
  output logic [NUM_LANES-1:0]    serial_out,
  output logic                    send_done,
  output logic                    send_fail,
  output logic                    cur_seq
);

  localparam int W     = PAYLOAD_BITS / NUM_LANES;
  localparam int CNT_W = $clog2(W + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 2);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W);
  localparam logic [TMR_W-1:0] LAST_TMR = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] MAX_RTY  = RTY_W'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t                         state_q, state_nxt;
  logic [CNT_W-1:0]               cnt_q, cnt_nxt;
  logic [TMR_W-1:0]               timer_q, timer_nxt;
  logic [RTY_W-1:0]               retries_q, retries_nxt;
  logic                           seq_q, seq_nxt;
  logic                           need_ack_q;
  logic                           done_q, done_nxt;
  logic                           fail_q, fail_nxt;
  logic                           load_new, load_retry;

  logic [PAYLOAD_BITS-1:0]        payload_q;
  logic [TYPE_BITS-1:0]           type_q;
  logic [PAYLOAD_BITS-1:0]        frame_payload;
  logic [TYPE_BITS-1:0]           frame_type;
  logic [NUM_LANES-1:0][W:0]      lane_sr_q;
  logic [W:0]                     hdr_sr_q;

  // Header lane image, MSB transmitted first: start bit, type, seq, then zeros.
  function automatic logic [W:0] hdr_frame(input logic [TYPE_BITS-1:0] t,
                                           input logic s);
    logic [W:0] f;
    f = '0;
    f[W] = 1'b1;
    f[W-1 -: TYPE_BITS] = t;
    f[W-1-TYPE_BITS] = s;
    return f;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic: frame counting, ack matching, timeout and retry decisions.
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    timer_nxt   = timer_q;
    retries_nxt = retries_q;
    seq_nxt     = seq_q;
    done_nxt    = 1'b0;
    fail_nxt    = 1'b0;
    load_new    = 1'b0;
    load_retry  = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_valid) begin
          state_nxt   = SEND;
          cnt_nxt     = '0;
          retries_nxt = '0;
          load_new    = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == LAST_CNT) begin
          cnt_nxt = '0;
          if (need_ack_q) begin
            state_nxt = WAIT_ACK;
            timer_nxt = '0;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            seq_nxt   = ~seq_q;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        // A matching ack wins even on the final timeout cycle.
        if (ack_valid && (ack_seq == seq_q)) begin
          state_nxt   = IDLE;
          done_nxt    = 1'b1;
          seq_nxt     = ~seq_q;
          retries_nxt = '0;
        end else if (timer_q == LAST_TMR) begin
          if (retries_q < MAX_RTY) begin
            state_nxt   = SEND;
            cnt_nxt     = '0;
            retries_nxt = retries_q + RTY_W'(1);
            load_retry  = 1'b1;
          end else begin
            state_nxt   = IDLE;
            fail_nxt    = 1'b1;
            retries_nxt = '0;
          end
        end else begin
          timer_nxt = timer_q + TMR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: counters, sequence bit, latched need_ack and pulses.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q      <= '0;
      timer_q    <= '0;
      retries_q  <= '0;
      seq_q      <= 1'b0;
      need_ack_q <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_nxt;
      timer_q   <= timer_nxt;
      retries_q <= retries_nxt;
      seq_q     <= seq_nxt;
      done_q    <= done_nxt;
      fail_q    <= fail_nxt;
      if (load_new) need_ack_q <= send_need_ack;
    end
  end

  // Payload and type held for retransmission; pure data, so no reset.
  always_ff @(posedge clk) begin
    if (load_new) begin
      payload_q <= send_payload;
      type_q    <= send_type;
    end
  end

  assign frame_payload = load_retry ? payload_q : send_payload;
  assign frame_type    = load_retry ? type_q    : send_type;

  // Frame shifters: load a full frame image, then shift zeros in so the lanes
  // fall back to 0 exactly after the W+1 frame cycles.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lane_sr_q <= '0;
      hdr_sr_q  <= '0;
    end else if (load_new || load_retry) begin
      for (int i = 0; i < NUM_LANES; i++)
        lane_sr_q[i] <= {1'b1, frame_payload[i*W +: W]};
      hdr_sr_q <= hdr_frame(frame_type, seq_q);
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        lane_sr_q[i] <= {lane_sr_q[i][W-1:0], 1'b0};
      hdr_sr_q <= {hdr_sr_q[W-1:0], 1'b0};
    end
  end

  // Each data lane is the MSB of its shifter.
  always_comb begin
    serial_out = '0;
    for (int i = 0; i < NUM_LANES; i++)
      serial_out[i] = lane_sr_q[i][W];
  end

  assign serial_out_h = hdr_sr_q[W];
  assign send_ready   = (state_q == IDLE);
  assign send_done    = done_q;
  assign send_fail    = fail_q;
  assign cur_seq      = seq_q;

endmodule

// File: tb/tb_lane_packet_sender.sv
// Bench for lane_packet_sender: packet-level reference model plus directed
// literal cases and a randomized run on the default configuration, and a
// directed frame check on an 8-lane / 64-bit instance.
module tb_lane_packet_sender;

  localparam int NL = 4, PB = 32, TB = 3, TO = 16, MR = 2, W = PB / NL;
  localparam int NLB = 8, PBB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l = 1'b0;

  logic          send_valid = 1'b0, send_need_ack = 1'b0;
  logic [TB-1:0] send_type = '0;
  logic [PB-1:0] send_payload = '0;
  logic          ack_valid = 1'b0, ack_seq = 1'b0;
  logic          send_ready, serial_out_h, send_done, send_fail, cur_seq;
  logic [NL-1:0] serial_out;

  logic           b_send_valid = 1'b0, b_send_need_ack = 1'b0;
  logic [2:0]     b_send_type = '0;
  logic [PBB-1:0] b_send_payload = '0;
  logic           b_send_ready, b_serial_out_h, b_send_done, b_send_fail, b_cur_seq;
  logic [NLB-1:0] b_serial_out;

  lane_packet_sender #(.NUM_LANES(NL), .PAYLOAD_BITS(PB), .TYPE_BITS(TB),
                       .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst_l(rst_l), .send_valid(send_valid), .send_ready(send_ready),
    .send_type(send_type), .send_need_ack(send_need_ack), .send_payload(send_payload),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .serial_out_h(serial_out_h),
    .serial_out(serial_out), .send_done(send_done), .send_fail(send_fail),
    .cur_seq(cur_seq));

  lane_packet_sender #(.NUM_LANES(NLB), .PAYLOAD_BITS(PBB), .TYPE_BITS(3),
                       .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut_b (
    .clk(clk), .rst_l(rst_l), .send_valid(b_send_valid), .send_ready(b_send_ready),
    .send_type(b_send_type), .send_need_ack(b_send_need_ack), .send_payload(b_send_payload),
    .ack_valid(1'b0), .ack_seq(1'b0), .serial_out_h(b_serial_out_h),
    .serial_out(b_serial_out), .send_done(b_send_done), .send_fail(b_send_fail),
    .cur_seq(b_cur_seq));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet in flight is described by its offset m_t from
  // the start of the current attempt (0..W frame, W+1..W+TO waiting for ack).
  bit          m_busy = 0, m_done = 0, m_fail = 0, m_seq = 0, m_na = 0;
  int          m_t = 0, m_try = 0;
  logic [PB-1:0] m_pl = '0;
  logic [TB-1:0] m_ty = '0;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_busy = 0; m_done = 0; m_fail = 0; m_seq = 0; m_t = 0; m_try = 0;
    end else begin
      m_done = 0;
      m_fail = 0;
      if (!m_busy) begin
        if (send_valid) begin
          m_busy = 1; m_t = 0; m_try = 0;
          m_pl = send_payload; m_ty = send_type; m_na = send_need_ack;
        end
      end else if (m_t < W) begin
        m_t++;
      end else if (m_t == W && !m_na) begin
        m_busy = 0; m_done = 1; m_seq = ~m_seq;
      end else if (m_t > W && ack_valid && ack_seq == m_seq) begin
        m_busy = 0; m_done = 1; m_seq = ~m_seq;
      end else if (m_t == W + TO) begin
        if (m_try < MR) begin
          m_try++; m_t = 0;
        end else begin
          m_busy = 0; m_fail = 1;
        end
      end else begin
        m_t++;
      end
    end
  end

  function automatic logic [8:0] model_vec();
    logic [NL-1:0] ln;
    logic h;
    ln = '0;
    h = 1'b0;
    if (m_busy && m_t <= W) begin
      for (int i = 0; i < NL; i++)
        ln[i] = (m_t == 0) ? 1'b1 : m_pl[i*W + W - m_t];
      if (m_t == 0)            h = 1'b1;
      else if (m_t <= TB)      h = m_ty[TB - m_t];
      else if (m_t == TB + 1)  h = m_seq;
    end
    return {~m_busy, m_done, m_fail, m_seq, h, ln};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {send_ready, send_done, send_fail, cur_seq, serial_out_h, serial_out};
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) chk("cycle_outputs", 64'(dut_vec()), 64'(model_vec()));
  end

  logic       hist [0:255];
  logic [8:0] l0, l1, l2, l3, hb;

  function automatic logic [8:0] hist_frame(input int s);
    logic [8:0] f;
    for (int k = 0; k < 9; k++) f[8-k] = hist[s+k];
    return f;
  endfunction

  // Drive one packet from IDLE; n counts negedges after the handshake edge.
  task automatic send_pkt(input logic [TB-1:0] ty, input logic na, input logic [PB-1:0] pl,
                          input int ack_at, input logic ack_s, input int bad_at,
                          output int end_n, output logic failed);
    end_n = -1;
    failed = 1'b0;
    for (int k = 0; k < 256; k++) hist[k] = 1'b0;
    @(negedge clk);
    send_valid = 1'b1; send_type = ty; send_need_ack = na; send_payload = pl; ack_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        send_valid = 1'b0; send_type = ~ty; send_payload = ~pl; send_need_ack = ~na;
      end
      hist[n] = serial_out_h;
      if (n <= 9) begin
        l0[9-n] = serial_out[0]; l1[9-n] = serial_out[1];
        l2[9-n] = serial_out[2]; l3[9-n] = serial_out[3];
        hb[9-n] = serial_out_h;
      end
      ack_valid = (n == ack_at) || (n == bad_at);
      ack_seq = (n == ack_at) ? ack_s : ~ack_s;
      if (send_done || send_fail) begin
        end_n = n;
        failed = send_fail;
        break;
      end
    end
    ack_valid = 1'b0;
    if (end_n < 0) begin
      errors++;
      checks++;
      $display("FAIL pkt_end_timeout actual=none required=done_or_fail");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1 chk("reset_state", 64'(dut_vec()), 64'(9'h100));
    @(negedge clk);
    #2 rst_l = 1'b1;
  endtask

  int         en;
  logic       fl;
  logic [8:0] bl [0:NLB-1];
  int         rate;

  initial begin
    repeat (2) @(negedge clk);
    chk("power_on_reset", 64'(dut_vec()), 64'(9'h100));
    chk_en = 1'b1;
    #2 rst_l = 1'b1;

    // Fire-and-forget reference packet.
    send_pkt(3'b101, 1'b0, 32'hA5C30F81, -1, 1'b0, -1, en, fl);
    chk("fnf_end_cycle", 64'(en), 64'(10));
    chk("fnf_not_fail", 64'(fl), 64'(0));
    chk("fnf_lane0", 64'(l0), 64'(9'b1_1000_0001));
    chk("fnf_lane1", 64'(l1), 64'(9'b1_0000_1111));
    chk("fnf_lane2", 64'(l2), 64'(9'b1_1100_0011));
    chk("fnf_lane3", 64'(l3), 64'(9'b1_1010_0101));
    chk("fnf_header", 64'(hb), 64'(9'b1_1010_0000));
    chk("fnf_seq_toggled", 64'(cur_seq), 64'(1));

    // Ack after a wrong-seq ack; done follows the matching one.
    do_reset();
    send_pkt(3'b010, 1'b1, 32'h1234_5678, 13, 1'b0, 11, en, fl);
    chk("ack_end_cycle", 64'(en), 64'(14));
    chk("ack_not_fail", 64'(fl), 64'(0));
    chk("ack_seq_toggled", 64'(cur_seq), 64'(1));

    // No ack at all: three identical frames then failure.
    do_reset();
    send_pkt(3'b110, 1'b1, 32'hCAFE_F00D, -1, 1'b0, -1, en, fl);
    chk("fail_end_cycle", 64'(en), 64'(76));
    chk("fail_flag", 64'(fl), 64'(1));
    chk("fail_seq_kept", 64'(cur_seq), 64'(0));
    chk("fail_hdr_frame1", 64'(hist_frame(1)), 64'(9'b1_1100_0000));
    chk("fail_hdr_frame2", 64'(hist_frame(26)), 64'(9'b1_1100_0000));
    chk("fail_hdr_frame3", 64'(hist_frame(51)), 64'(9'b1_1100_0000));
    chk("fail_gap_quiet", 64'(hist[25]), 64'(0));

    // Matching ack exactly on the timeout cycle wins over retransmit.
    send_pkt(3'b001, 1'b1, 32'h0F0F_0F0F, 25, 1'b0, -1, en, fl);
    chk("tmo_ack_end_cycle", 64'(en), 64'(26));
    chk("tmo_ack_not_fail", 64'(fl), 64'(0));
    chk("tmo_ack_no_resend", 64'(hist[26]), 64'(0));
    chk("tmo_ack_seq", 64'(cur_seq), 64'(1));

    // Reset during frame cycle 4 aborts immediately.
    @(negedge clk);
    send_valid = 1'b1; send_type = 3'b111; send_need_ack = 1'b1; send_payload = 32'hFFFF_FFFF;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      send_valid = 1'b0;
    end
    chk("abort_pre_hdr_seq", 64'(serial_out_h), 64'(1));
    #2 rst_l = 1'b0;
    #1 chk("abort_outputs", 64'(dut_vec()), 64'(9'h100));
    @(negedge clk);
    #2 rst_l = 1'b1;
    repeat (3) @(negedge clk);

    // Eight-lane instance: 9-cycle frame, lane i carries payload byte i.
    @(negedge clk);
    b_send_valid = 1'b1; b_send_type = 3'b011; b_send_payload = 64'hDEAD_BEEF_0123_4567;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      b_send_valid = 1'b0;
      for (int i = 0; i < NLB; i++) bl[i][9-n] = b_serial_out[i];
    end
    @(negedge clk);
    chk("b_done_cycle10", 64'(b_send_done), 64'(1));
    chk("b_lane7", 64'(bl[7]), 64'(9'h1DE));
    chk("b_lane0", 64'(bl[0]), 64'(9'h167));
    for (int i = 0; i < NLB; i++)
      chk("b_lane_i", 64'(bl[i]), 64'({1'b1, b_send_payload[i*8 +: 8]}));

    // Randomized traffic with varying ack density and occasional resets.
    rate = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0: rate = 0;
          1: rate = 4;
          default: rate = 20;
        endcase
      end
      if (!rst_l) #2 rst_l = 1'b1;
      send_valid    = ($urandom_range(0, 3) == 0);
      send_type     = TB'($urandom);
      send_need_ack = 1'($urandom);
      send_payload  = $urandom;
      ack_valid     = (rate > 0) && ($urandom_range(0, rate - 1) == 0);
      ack_seq       = 1'($urandom);
      if ($urandom_range(0, 399) == 0) #2 rst_l = 1'b0;
    end
    @(negedge clk);
    #2 rst_l = 1'b1;
    send_valid = 1'b0;
    ack_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
